// File: rtl/ov5640_init_pkg.sv
// Shared types and constants for the OV5640 init sequencer.
// Defining OV5640_INIT_READBACK_EN adds the RD_ISSUE/RD_WAIT read-verify states.
package ov5640_init_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PWRUP,
    FETCH,
    LATCH,
    ISSUE,
    WAIT_DONE,
    SETTLE,
    NEXT,
    DONE,
    ERROR
`ifdef OV5640_INIT_READBACK_EN
    ,
    RD_ISSUE,
    RD_WAIT
`endif
  } state_t;

  // ROM entry layout: {reg_addr[15:0], reg_data[7:0]}
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  function automatic logic [31:0] ms_to_cycles(input int unsigned ms, input int unsigned clk_hz);
    return ms * (clk_hz / 32'd1000);
  endfunction

endpackage

// File: rtl/init_delay_timer.sv
// One-shot down-counter: start loads a cycle count, expired is high for exactly one
// cycle once that many cycles have elapsed since start (load of 0 behaves as 1).
module init_delay_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] load,
  output logic        expired
);

  logic [31:0] cnt;
  logic        running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= (load == 32'd0) ? 32'd0 : load - 32'd1;
      running <= 1'b1;
    end else if (running) begin
      if (cnt == 32'd0) running <= 1'b0;
      else              cnt     <= cnt - 32'd1;
    end
  end

  assign expired = running && (cnt == 32'd0);

endmodule

// File: rtl/ov5640_init_sequencer.sv
// Walks the OV5640 init ROM and issues one SCCB write per entry, with power-up and
// post-soft-reset waits and NACK retries. OV5640_INIT_READBACK_EN adds read-verify.
import ov5640_init_pkg::*;

module ov5640_init_sequencer #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int          ROM_ADDR_WIDTH = 8,
  parameter int          TABLE_LEN      = 252,
  parameter int          RESET_IDX      = 1,
  parameter int unsigned PWRUP_MS       = 20,
  parameter int unsigned RESET_MS       = 5,
  parameter int          MAX_RETRY      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]               rom_q,
  // Handshake: a request is held with stable addr/data until the one-cycle ack, after
  // which it drops; the transfer then completes with a one-cycle done (err valid with it).
  output logic                      wr_req,
  output logic [15:0]               wr_addr,
  output logic [7:0]                wr_data,
  input  logic                      wr_ack,
  input  logic                      wr_done,
  input  logic                      wr_err,
`ifdef OV5640_INIT_READBACK_EN
  output logic                      rd_req,
  input  logic                      rd_ack,
  input  logic                      rd_done,
  input  logic [7:0]                rd_data,
`endif
  output logic                      busy,
  output logic                      init_done,
  output logic                      init_err,
  output logic [ROM_ADDR_WIDTH-1:0] err_idx,
  output state_t                    dbg_state
);

  localparam logic [31:0] PWRUP_FULL = ms_to_cycles(PWRUP_MS, CLK_FREQ);
  // FETCH and LATCH add two cycles before wr_req rises, so the timer covers the rest.
  localparam logic [31:0] PWRUP_CYC  = (PWRUP_FULL > 32'd2) ? PWRUP_FULL - 32'd2 : 32'd1;
  localparam logic [31:0] SETTLE_CYC = ms_to_cycles(RESET_MS, CLK_FREQ);
  localparam int          RW         = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]             MAX_R    = RW'(MAX_RETRY);
  localparam logic [ROM_ADDR_WIDTH-1:0] LAST_IDX = ROM_ADDR_WIDTH'(TABLE_LEN - 1);
  localparam logic [ROM_ADDR_WIDTH-1:0] RST_IDX  = ROM_ADDR_WIDTH'(RESET_IDX);

  state_t                    state;
  logic [ROM_ADDR_WIDTH-1:0] idx;
  logic [RW-1:0]             retry_cnt;
  logic                      start_q;
  logic                      start_edge;
  logic                      wr_ok;
  logic                      attempt_fail;
  logic                      tmr_start;
  logic [31:0]               tmr_load;
  logic                      tmr_expired;

  assign rom_addr   = idx;
  assign dbg_state  = state;
  assign start_edge = start && !start_q;
  assign wr_ok      = (state == WAIT_DONE) && wr_done && !wr_ack && !wr_err;

  always_comb begin
    attempt_fail = (state == WAIT_DONE) && wr_done && !wr_ack && wr_err;
`ifdef OV5640_INIT_READBACK_EN
    if ((state == RD_WAIT) && rd_done && !rd_ack && (wr_err || (rd_data != wr_data)))
      attempt_fail = 1'b1;
`endif
  end

  always_comb begin
    tmr_start = 1'b0;
    tmr_load  = PWRUP_CYC;
    if ((state == IDLE || state == DONE || state == ERROR) && start_edge) tmr_start = 1'b1;
    if (wr_ok && (idx == RST_IDX)) begin
      tmr_start = 1'b1;
      tmr_load  = SETTLE_CYC;
    end
  end

  init_delay_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (tmr_start),
    .load    (tmr_load),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      retry_cnt <= '0;
      start_q   <= 1'b1;  // a start held high through reset must not look like an edge
      wr_req    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
      init_err  <= 1'b0;
      err_idx   <= '0;
`ifdef OV5640_INIT_READBACK_EN
      rd_req    <= 1'b0;
`endif
    end else begin
      start_q <= start;
      if (attempt_fail) begin
        if (retry_cnt < MAX_R) begin
          retry_cnt <= retry_cnt + RW'(1);
          wr_req    <= 1'b1;
          state     <= ISSUE;
        end else begin
          err_idx  <= idx;
          init_err <= 1'b1;
          busy     <= 1'b0;
          state    <= ERROR;
        end
      end else begin
        case (state)
          IDLE, DONE, ERROR: if (start_edge) begin
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_idx   <= '0;
            idx       <= '0;
            retry_cnt <= '0;
            busy      <= 1'b1;
            state     <= PWRUP;
          end
          PWRUP:  if (tmr_expired) state <= FETCH;
          FETCH:  state <= LATCH;
          LATCH: begin
            wr_addr <= rom_q[ADDR_MSB:ADDR_LSB];
            wr_data <= rom_q[DATA_MSB:0];
            wr_req  <= 1'b1;
            state   <= ISSUE;
          end
          ISSUE: if (wr_ack) begin
            wr_req <= 1'b0;
            state  <= WAIT_DONE;
          end
          WAIT_DONE: if (wr_ok) begin
            if (idx == RST_IDX) begin
              state <= SETTLE;
            end else begin
`ifdef OV5640_INIT_READBACK_EN
              rd_req <= 1'b1;
              state  <= RD_ISSUE;
`else
              state  <= NEXT;
`endif
            end
          end
`ifdef OV5640_INIT_READBACK_EN
          RD_ISSUE: if (rd_ack) begin
            rd_req <= 1'b0;
            state  <= RD_WAIT;
          end
          RD_WAIT: if (rd_done && !rd_ack) state <= NEXT;
`endif
          SETTLE: if (tmr_expired) state <= NEXT;
          NEXT: begin
            retry_cnt <= '0;
            if (idx == LAST_IDX) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end else begin
              idx   <= idx + ROM_ADDR_WIDTH'(1);
              state <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
